// File: rtl/gpo_pad_ctrl.sv
// gpo_pad_ctrl: config sequencer for one EG1D80V GPO pad cell.
// Applies register-file config requests to the pad glitch-free:
// tristate (OE low), optionally wait for VBIAS, apply DS/SR/OD, settle, restore OE.
// Ports:
//   CLK_I, RST_I           clock, async active-high reset
//   cfg_req_i / cfg_ack_o  request (held until ack) / one-cycle completion pulse
//   cfg_ds_i/sr_i/od_i/oe_i requested drive strength, slew, open-drain mode, OE
//   do_i / pad_do_o        core data, registered through to the pad
//   bias_ok_i              async VBIAS-good, 2-flop synchronised here
//   pad_ds/sr/co/oe/odp/odn_o  pad pin drives
//   busy_o                 sequencer not idle
//   bias_err_o             sticky bias failure, cleared by next accepted request
module gpo_pad_ctrl #(
  parameter int BREAK_CYC  = 4,
  parameter int SETTLE_CYC = 8,
  parameter int BIAS_CYC   = 64,
  parameter int BIAS_TMO   = 1024
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       cfg_req_i,
  input  logic [1:0] cfg_ds_i,
  input  logic       cfg_sr_i,
  input  logic [1:0] cfg_od_i,
  input  logic       cfg_oe_i,
  output logic       cfg_ack_o,
  input  logic       do_i,
  input  logic       bias_ok_i,
  output logic       pad_do_o,
  output logic [1:0] pad_ds_o,
  output logic       pad_sr_o,
  output logic       pad_co_o,
  output logic       pad_oe_o,
  output logic       pad_odp_o,
  output logic       pad_odn_o,
  output logic       busy_o,
  output logic       bias_err_o
);

  localparam int CMAX = (BREAK_CYC > SETTLE_CYC) ? BREAK_CYC : SETTLE_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int OW   = $clog2(BIAS_CYC + 1);
  localparam int TW   = $clog2(BIAS_TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BREAK, S_BIAS, S_APPLY, S_SETTLE, S_DONE
  } state_t;

  typedef struct packed {
    logic [1:0] ds;
    logic       sr;
    logic [1:0] od;
    logic       oe;
  } pad_cfg_t;

  state_t    state;
  pad_cfg_t  sh;
  logic [CW-1:0] cnt;
  logic [OW-1:0] ok_cnt;
  logic [TW-1:0] tmo_cnt;
  logic      bias_s1, bias_s2;

  assign pad_co_o = 1'b0;
  assign busy_o   = (state != S_IDLE);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state      <= S_IDLE;
      sh         <= '0;
      cnt        <= '0;
      ok_cnt     <= '0;
      tmo_cnt    <= '0;
      bias_s1    <= 1'b0;
      bias_s2    <= 1'b0;
      cfg_ack_o  <= 1'b0;
      pad_do_o   <= 1'b0;
      pad_ds_o   <= 2'b00;
      pad_sr_o   <= 1'b1;
      pad_oe_o   <= 1'b0;
      pad_odp_o  <= 1'b0;
      pad_odn_o  <= 1'b0;
      bias_err_o <= 1'b0;
    end else begin
      bias_s1   <= bias_ok_i;
      bias_s2   <= bias_s1;
      pad_do_o  <= do_i;
      cfg_ack_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_req_i) begin
            sh         <= '{ds: cfg_ds_i, sr: cfg_sr_i, od: cfg_od_i, oe: cfg_oe_i};
            bias_err_o <= 1'b0;
            pad_oe_o   <= 1'b0;
            cnt        <= '0;
            state      <= S_BREAK;
            // never keep DS up without bias, even while starting a new request
            if (!bias_s2) pad_ds_o <= 2'b00;
          end else if (!bias_s2 && pad_ds_o != 2'b00) begin
            // bias lost under an active drive: tristate and drop DS; stays so until next request
            pad_oe_o   <= 1'b0;
            pad_ds_o   <= 2'b00;
            bias_err_o <= 1'b1;
          end
        end
        S_BREAK: begin
          if (cnt == CW'(BREAK_CYC - 1)) begin
            cnt     <= '0;
            ok_cnt  <= '0;
            tmo_cnt <= '0;
            state   <= (sh.ds != 2'b00) ? S_BIAS : S_APPLY;
          end else if (cnt != CW'(CMAX)) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BIAS: begin
          if (tmo_cnt != TW'(BIAS_TMO)) tmo_cnt <= tmo_cnt + 1'b1;
          if (!bias_s2)                      ok_cnt <= '0;
          else if (ok_cnt != OW'(BIAS_CYC)) ok_cnt <= ok_cnt + 1'b1;
          // ok_cnt holds the run of 1s before this cycle, so this cycle completes the run
          if (bias_s2 && ok_cnt == OW'(BIAS_CYC - 1)) begin
            state <= S_APPLY;
          end else if (tmo_cnt == TW'(BIAS_TMO - 1)) begin
            sh.ds      <= 2'b00;
            bias_err_o <= 1'b1;
            state      <= S_APPLY;
          end
        end
        S_APPLY: begin
          pad_ds_o  <= sh.ds;
          pad_sr_o  <= sh.sr;
          pad_odp_o <= (sh.od == 2'b10);
          pad_odn_o <= (sh.od == 2'b01);
          cnt       <= '0;
          state     <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == CW'(SETTLE_CYC - 1)) begin
            pad_oe_o <= sh.oe;
            state    <= S_DONE;
          end else if (cnt != CW'(CMAX)) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          cfg_ack_o <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpo_pad_ctrl.sv
// tb_gpo_pad_ctrl: directed + randomized bench for gpo_pad_ctrl.
// Reference model: the expected ack latency and final pin state of each request are
// derived from the bias_ok pattern (synchroniser delay, run-length of 1s, timeout).
module tb_gpo_pad_ctrl;
  localparam int BREAK_CYC  = 4;
  localparam int SETTLE_CYC = 8;
  localparam int BIAS_CYC   = 64;
  localparam int BIAS_TMO   = 1024;
  localparam int PATN       = BIAS_TMO + BREAK_CYC + SETTLE_CYC + 40;

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b1;
  logic       cfg_req_i = 1'b0;
  logic [1:0] cfg_ds_i = '0;
  logic       cfg_sr_i = 1'b0;
  logic [1:0] cfg_od_i = '0;
  logic       cfg_oe_i = 1'b0;
  logic       cfg_ack_o;
  logic       do_i = 1'b0;
  logic       bias_ok_i = 1'b1;
  logic       pad_do_o, pad_sr_o, pad_co_o, pad_oe_o, pad_odp_o, pad_odn_o;
  logic [1:0] pad_ds_o;
  logic       busy_o, bias_err_o;

  gpo_pad_ctrl #(.BREAK_CYC(BREAK_CYC), .SETTLE_CYC(SETTLE_CYC),
                 .BIAS_CYC(BIAS_CYC), .BIAS_TMO(BIAS_TMO)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .cfg_req_i(cfg_req_i), .cfg_ds_i(cfg_ds_i),
    .cfg_sr_i(cfg_sr_i), .cfg_od_i(cfg_od_i), .cfg_oe_i(cfg_oe_i), .cfg_ack_o(cfg_ack_o),
    .do_i(do_i), .bias_ok_i(bias_ok_i), .pad_do_o(pad_do_o), .pad_ds_o(pad_ds_o),
    .pad_sr_o(pad_sr_o), .pad_co_o(pad_co_o), .pad_oe_o(pad_oe_o), .pad_odp_o(pad_odp_o),
    .pad_odn_o(pad_odn_o), .busy_o(busy_o), .bias_err_o(bias_err_o));

  always #5 CLK_I = ~CLK_I;

  int   checks = 0;
  int   errors = 0;
  bit   pat[PATN];     // bias_ok_i value sampled at edge e after request acceptance (edge 0)
  logic prev_do = 1'b0;
  logic prev_oe = 1'b0;
  logic [4:0] prev_pins = 5'b00100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: sample after the edge, check echo and OE/pin invariant, drive fresh do_i
  task automatic tick();
    logic [4:0] pins;
    @(posedge CLK_I);
    #1;
    pins = {pad_ds_o, pad_sr_o, pad_odp_o, pad_odn_o};
    if (!RST_I) chk("do_echo", pad_do_o, prev_do);
    chk("oe_rise_with_pin_change", (pad_oe_o && !prev_oe && pins != prev_pins), 0);
    prev_oe   = pad_oe_o;
    prev_pins = pins;
    do_i      = 1'($urandom);
    prev_do   = do_i;
  endtask

  // cycles spent waiting for bias: sync value at edge e is the raw value from edge e-2
  function automatic int bias_wait(output bit tmo);
    int run;
    int e;
    run = 0;
    tmo = 1'b0;
    for (int k = 0; k < BIAS_TMO; k++) begin
      e   = BREAK_CYC + 1 + k;
      run = pat[e-2] ? run + 1 : 0;
      if (run >= BIAS_CYC) return k + 1;
    end
    tmo = 1'b1;
    return BIAS_TMO;
  endfunction

  // mode: 0 bias steady high, 1 toggling every 30 cycles, 2 random run lengths
  task automatic run_req(input logic [1:0] ds, input logic sr, input logic [1:0] od,
                         input logic oe, input int mode);
    int  b, lat, got, idx;
    bit  tmo, v;
    logic [1:0] exp_ds;
    idx = 0;
    v   = 1'($urandom);
    while (idx < PATN) begin
      int len;
      len = $urandom_range(20, 120);
      for (int j = 0; j < len && idx < PATN; j++) begin
        pat[idx] = (mode == 0) ? 1'b1 : (mode == 1) ? (((idx / 30) % 2) == 0) : v;
        idx++;
      end
      v = ~v;
    end
    tmo = 1'b0;
    b   = (ds != 2'b00) ? bias_wait(tmo) : 0;
    lat = BREAK_CYC + SETTLE_CYC + 2 + b;
    exp_ds = tmo ? 2'b00 : ds;

    cfg_ds_i = ds; cfg_sr_i = sr; cfg_od_i = od; cfg_oe_i = oe;
    cfg_req_i = 1'b1;
    bias_ok_i = pat[0];
    got = -1;
    for (int e = 0; e < PATN - 1 && got < 0; e++) begin
      tick();
      bias_ok_i = pat[e+1];
      if (e == 0) begin
        chk("busy_after_accept", busy_o, 1);
        chk("err_clear_on_accept", bias_err_o, 0);
      end
      if (e == BREAK_CYC) chk("oe_low_in_break", pad_oe_o, 0);
      if (cfg_ack_o) begin
        got = e;
        cfg_req_i = 1'b0;
      end
    end
    chk("ack_latency", got, lat);
    chk("pad_ds", pad_ds_o, exp_ds);
    chk("pad_sr", pad_sr_o, sr);
    chk("pad_odp", pad_odp_o, (od == 2'b10));
    chk("pad_odn", pad_odn_o, (od == 2'b01));
    chk("pad_oe", pad_oe_o, oe);
    chk("bias_err", bias_err_o, tmo);
    bias_ok_i = 1'b1;
    tick();
    chk("ack_single_pulse", cfg_ack_o, 0);
    chk("idle_after_ack", busy_o, 0);
    tick();
    tick();
  endtask

  initial begin
    RST_I = 1'b1;
    #12;
    chk("rst_oe", pad_oe_o, 0);
    chk("rst_ds", pad_ds_o, 0);
    chk("rst_sr", pad_sr_o, 1);
    chk("rst_odp", pad_odp_o, 0);
    chk("rst_odn", pad_odn_o, 0);
    chk("rst_co", pad_co_o, 0);
    chk("rst_ack", cfg_ack_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", bias_err_o, 0);
    chk("rst_do", pad_do_o, 0);
    @(negedge CLK_I);
    RST_I = 1'b0;
    repeat (4) tick();

    // basic sequence, no bias wait
    run_req(2'b00, 1'b0, 2'b00, 1'b1, 0);
    // strong drive with bias held good
    run_req(2'b11, 1'b1, 2'b00, 1'b1, 0);
    // bias toggling too fast -> timeout fallback
    run_req(2'b10, 1'b0, 2'b00, 1'b1, 1);

    // bias loss while idle with DS active
    run_req(2'b01, 1'b0, 2'b00, 1'b1, 0);
    bias_ok_i = 1'b0;
    tick();
    chk("bias_loss_not_yet", pad_ds_o, 2'b01);
    tick();
    tick();
    chk("bias_loss_oe", pad_oe_o, 0);
    chk("bias_loss_ds", pad_ds_o, 0);
    chk("bias_loss_err", bias_err_o, 1);
    bias_ok_i = 1'b1;
    repeat (3) tick();
    chk("bias_err_sticky", bias_err_o, 1);
    run_req(2'b00, 1'b0, 2'b00, 1'b1, 0);

    // open-drain modes, and OE requested off
    run_req(2'b00, 1'b0, 2'b01, 1'b1, 0);
    run_req(2'b00, 1'b1, 2'b10, 1'b1, 0);
    run_req(2'b00, 1'b0, 2'b11, 1'b1, 0);
    run_req(2'b00, 1'b1, 2'b00, 1'b0, 0);

    // randomized requests against random bias patterns
    for (int i = 0; i < 4; i++)
      run_req(2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 2);

    // reset during SETTLE
    cfg_ds_i = 2'b00; cfg_sr_i = 1'b0; cfg_od_i = 2'b10; cfg_oe_i = 1'b1;
    cfg_req_i = 1'b1;
    repeat (BREAK_CYC + 3) tick();
    chk("in_settle_busy", busy_o, 1);
    chk("in_settle_odp", pad_odp_o, 1);
    RST_I = 1'b1;
    cfg_req_i = 1'b0;
    #1;
    chk("async_rst_odp", pad_odp_o, 0);
    chk("async_rst_sr", pad_sr_o, 1);
    chk("async_rst_busy", busy_o, 0);
    chk("async_rst_oe", pad_oe_o, 0);
    repeat (2) begin
      tick();
      chk("no_ack_in_reset", cfg_ack_o, 0);
    end
    RST_I = 1'b0;
    repeat (20) begin
      tick();
      chk("no_ack_after_abort", cfg_ack_o, 0);
      chk("idle_after_abort", busy_o, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
